// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, parameter
// defaults and small helpers used to size the shared timer.
package pll_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_RELEASE_GAP        = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 262144;
  localparam int unsigned DEF_PLL_RST_CYCLES     = 32;

  localparam int unsigned COUNT_W = 8;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Status/control bundle between the reset sequencer and the PLL plus the
// downstream clock domains it holds in reset.
interface pll_reset_sequencer_if ();
  import pll_reset_sequencer_pkg::*;

  logic               locked;
  logic               pll_rst;
  logic               core_reset_n;
  logic               panel_reset_n;
  logic               ready;
  logic [COUNT_W-1:0] lock_lost_count;
  logic [COUNT_W-1:0] timeout_count;

  modport master (
    input  locked,
    output pll_rst, core_reset_n, panel_reset_n, ready,
    output lock_lost_count, timeout_count
  );

  modport slave (
    output locked,
    input  pll_rst, core_reset_n, panel_reset_n, ready,
    input  lock_lost_count, timeout_count
  );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for slow asynchronous status inputs (PLL lock and
// similar level signals); not suitable for multi-bit buses that change together.
module sync_2ff #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and ordered core/panel reset release,
// retrying the PLL on lock timeout and falling back to WAIT_LOCK on lock loss.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   PLL_RST      | pll_rst held high for PLL_RST_CYCLES
//   WAIT_LOCK    | waiting for synchronized lock, retry PLL after LOCK_TIMEOUT
//   STABLE       | lock must stay high for LOCK_STABLE_CYCLES more samples
//   RELEASE      | core out of reset, panel still held for RELEASE_GAP
//   RUN          | both domains released, ready high
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned RELEASE_GAP        = DEF_RELEASE_GAP,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset_n,
  pll_reset_sequencer_if.master  bus
);

  localparam int unsigned CNT_MAX = max4(LOCK_STABLE_CYCLES, RELEASE_GAP,
                                         LOCK_TIMEOUT, PLL_RST_CYCLES);
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  // Timed states load N-1 so that they occupy exactly N cycles. Reset loads the
  // full count because the reset interval itself provides no entry edge.
  // STABLE loads the full count: the entry edge is the first high sample and
  // LOCK_STABLE_CYCLES further consecutive high samples are then required.
  localparam logic [CNT_W-1:0] LD_RESET   = CNT_W'(PLL_RST_CYCLES);
  localparam logic [CNT_W-1:0] LD_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LD_GAP     = CNT_W'(RELEASE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cnt_zero;
  logic               locked_sync;
  logic               tmo_inc, lost_inc;

  logic               pll_rst_q;
  logic               core_reset_n_q;
  logic               panel_reset_n_q;
  logic               ready_q;
  logic [COUNT_W-1:0] lock_lost_q;
  logic [COUNT_W-1:0] timeout_q;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.locked),
    .q       (locked_sync)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_zero ? cnt_q : cnt_q - CNT_ONE;
    tmo_inc  = 1'b0;
    lost_inc = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_zero) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = LD_TIMEOUT;
        end
      end

      ST_WAIT_LOCK: begin
        if (locked_sync) begin
          state_d = ST_STABLE;
          cnt_d   = LD_STABLE;
        end else if (cnt_zero) begin
          state_d = ST_PLL_RST;
          cnt_d   = LD_PLL_RST;
          tmo_inc = 1'b1;
        end
      end

      ST_STABLE: begin
        if (!locked_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = LD_TIMEOUT;
        end else if (cnt_zero) begin
          state_d = ST_RELEASE;
          cnt_d   = LD_GAP;
        end
      end

      ST_RELEASE: begin
        if (!locked_sync) begin
          state_d  = ST_WAIT_LOCK;
          cnt_d    = LD_TIMEOUT;
          lost_inc = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        if (!locked_sync) begin
          state_d  = ST_WAIT_LOCK;
          cnt_d    = LD_TIMEOUT;
          lost_inc = 1'b1;
        end
      end

      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = LD_PLL_RST;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PLL_RST;
      cnt_q   <= LD_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the next state so they switch on the edge entering a state;
  // panel release is only ever decoded from RUN, which always implies core release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst_q       <= 1'b1;
      core_reset_n_q  <= 1'b0;
      panel_reset_n_q <= 1'b0;
      ready_q         <= 1'b0;
    end else begin
      pll_rst_q       <= (state_d == ST_PLL_RST);
      core_reset_n_q  <= (state_d == ST_RELEASE) || (state_d == ST_RUN);
      panel_reset_n_q <= (state_d == ST_RUN);
      ready_q         <= (state_d == ST_RUN);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost_q <= '0;
      timeout_q   <= '0;
    end else begin
      if (lost_inc) lock_lost_q <= sat_inc(lock_lost_q);
      if (tmo_inc)  timeout_q   <= sat_inc(timeout_q);
    end
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.core_reset_n    = core_reset_n_q;
  assign bus.panel_reset_n   = panel_reset_n_q;
  assign bus.ready           = ready_q;
  assign bus.lock_lost_count = lock_lost_q;
  assign bus.timeout_count   = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues expected output
// changes (edge index + value), a monitor pops one per observed change.
module tb_pll_reset_sequencer;

  localparam int P_RST = 4;
  localparam int P_TMO = 20;
  localparam int P_STB = 8;
  localparam int P_GAP = 4;

  typedef struct {
    int          edge_i;
    logic [19:0] val;
  } ev_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (P_STB),
    .RELEASE_GAP        (P_GAP),
    .LOCK_TIMEOUT       (P_TMO),
    .PLL_RST_CYCLES     (P_RST)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #20 clock = ~clock;

  ev_t         exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          edge_n = 0;
  int          base   = 0;
  bit          mon_en = 1'b0;
  logic [19:0] out_vec;

  assign out_vec = {bus.pll_rst, bus.core_reset_n, bus.panel_reset_n, bus.ready,
                    bus.lock_lost_count, bus.timeout_count};

  always @(posedge clock) edge_n <= edge_n + 1;

  function automatic logic [19:0] mk(input bit p, input bit c, input bit pn, input bit r,
                                     input int l, input int t);
    return {p, c, pn, r, 8'(l), 8'(t)};
  endfunction

  localparam logic [19:0] RST_VEC = 20'h80000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_ev(input int e, input logic [19:0] v);
    ev_t ev;
    ev.edge_i = e;
    ev.val    = v;
    exp_q.push_back(ev);
  endtask

  // Returns 2 time units after the negedge that follows relative edge k.
  task automatic after_edge(input int k);
    while (edge_n - 1 - base < k) @(negedge clock);
    #2;
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() == 0) passes++;
    else begin
      $display("FAIL %s: %0d expected changes never seen, expected 0 pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    mon_en  = 1'b0;
    reset_n = 1'b0;
    bus.locked = 1'b0;
    #1;
    check("reset_state", 32'(out_vec), 32'(RST_VEC));
    repeat (3) @(negedge clock);
    #2;
    exp_q.delete();
    reset_n = 1'b1;
    base    = edge_n;
    mon_en  = 1'b1;
  endtask

  initial begin : monitor
    logic [19:0] prev, cur;
    ev_t         ev;
    prev = RST_VEC;
    forever begin
      @(negedge clock);
      cur = out_vec;
      if (reset_n) begin
        checks++;
        if (!(cur[17] && !cur[18])) passes++;
        else $display("FAIL reset_order: panel_reset_n=1 with core_reset_n=0 at t=%0t", $time);
      end
      if (mon_en && cur !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_change: got %h at edge %0d, expected no change",
                   cur, edge_n - 1 - base);
        end else begin
          ev = exp_q.pop_front();
          check("event_edge", 32'(edge_n - 1 - base), 32'(ev.edge_i));
          check("event_value", 32'(cur), 32'(ev.val));
        end
      end
      prev = cur;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.locked = 1'b0;
    #5;

    // Clean bring-up, lock loss in RUN, re-lock, then reset during RELEASE.
    do_reset();
    push_ev(4,  mk(0, 0, 0, 0, 0, 0));
    push_ev(18, mk(0, 1, 0, 0, 0, 0));
    push_ev(22, mk(0, 1, 1, 1, 0, 0));
    after_edge(6);
    bus.locked = 1'b1;
    after_edge(28);
    drain("bringup_seq");
    after_edge(30);
    bus.locked = 1'b0;
    push_ev(33, mk(0, 0, 0, 0, 1, 0));
    after_edge(35);
    bus.locked = 1'b1;
    push_ev(47, mk(0, 1, 0, 0, 1, 0));
    after_edge(48);
    drain("relock_seq");
    check("lost_count_before_reset", 32'(bus.lock_lost_count), 32'd1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset_in_release", 32'(out_vec), 32'(RST_VEC));
    @(negedge clock);
    check("reset_held", 32'(out_vec), 32'(RST_VEC));

    // One-cycle lock glitch in STABLE restarts qualification.
    do_reset();
    push_ev(4,  mk(0, 0, 0, 0, 0, 0));
    push_ev(25, mk(0, 1, 0, 0, 0, 0));
    push_ev(29, mk(0, 1, 1, 1, 0, 0));
    after_edge(6);
    bus.locked = 1'b1;
    after_edge(12);
    bus.locked = 1'b0;
    after_edge(13);
    bus.locked = 1'b1;
    after_edge(31);
    drain("glitch_seq");
    check("glitch_lost_count", 32'(bus.lock_lost_count), 32'd0);

    // No lock: retry every 24 cycles, timeout_count saturates at 255.
    do_reset();
    push_ev(4, mk(0, 0, 0, 0, 0, 0));
    for (int r = 1; r <= 256; r++) begin
      push_ev(24 * r,     mk(1, 0, 0, 0, 0, (r > 255) ? 255 : r));
      push_ev(24 * r + 4, mk(0, 0, 0, 0, 0, (r > 255) ? 255 : r));
    end
    after_edge(24 * 256 + 6);
    drain("retry_seq");
    check("timeout_saturated", 32'(bus.timeout_count), 32'd255);
    check("retry_not_ready", 32'(bus.ready), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, 1024: cycles the synchronized lock SHALL stay high before core reset release (legal range >=1).
REQ-002 Parameter RELEASE_GAP, 16: cycles between core and panel reset release (>=1).
REQ-003 Parameter LOCK_TIMEOUT, 262144: cycles without lock before a PLL reset retry is issued (>=1).
REQ-004 Parameter PLL_RST_CYCLES, 32: width in cycles of each pll_rst pulse (>=1).
REQ-005 clock  in  1  25 MHz board input clock (same net as the PLL reference); the block's single clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 locked  in  1  PLL lock, asynchronous to clock.
REQ-008 pll_rst  out  1  active-high reset to the PLL.
REQ-009 core_reset_n  out  1  active-low reset for the 125 MHz core domain.
REQ-010 panel_reset_n  out  1  active-low reset for the 52.0833 MHz panel domain.
REQ-011 ready  out  1  high only in RUN.
REQ-012 lock_lost_count  out  8  number of lock losses after release, saturating.
REQ-013 timeout_count  out  8  number of lock-timeout retries, saturating.

Function
REQ-014 locked SHALL pass through a 2-flop synchronizer (locked_sync); no other logic SHALL sample locked directly.
REQ-015 FSM states: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN; one shared down-counter sized for max(parameters).
REQ-016 PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK with counter loaded to LOCK_TIMEOUT.
REQ-017 WAIT_LOCK: locked_sync=1 -> STABLE (counter loaded LOCK_STABLE_CYCLES); counter expiry with locked_sync=0 -> PLL_RST, timeout_count+1; lock wins if both occur in the same cycle.
REQ-018 STABLE: locked_sync=0 -> WAIT_LOCK with timeout counter reloaded; LOCK_STABLE_CYCLES consecutive cycles high -> RELEASE.
REQ-019 RELEASE: core_reset_n=1, panel_reset_n=0; after RELEASE_GAP cycles -> RUN.
REQ-020 RUN: core_reset_n=1, panel_reset_n=1, ready=1.
REQ-021 locked_sync=0 in RELEASE or RUN -> WAIT_LOCK; core_reset_n, panel_reset_n, ready SHALL all be 0 from the next edge; lock_lost_count+1.
REQ-022 All outputs registered, decoded from next state, so they change on the edge that enters a state.
REQ-023 Both counts saturate at 255; no wrap.
REQ-024 Resets SHALL never deassert out of order: panel_reset_n=1 implies core_reset_n=1 in every cycle.
REQ-025 Downstream domains SHALL resynchronize deassertion locally; this block guarantees only glitch-free, registered outputs.

Reset
REQ-026 reset_n low (async): state PLL_RST, counter loaded PLL_RST_CYCLES, synchronizer cleared, pll_rst=1, core_reset_n=0, panel_reset_n=0, ready=0, counts=0.
REQ-027 reset_n assertion mid-sequence SHALL force the above immediately, regardless of state; deassertion restarts from PLL_RST.

Structure
REQ-028 State encodings and parameter defaults SHALL live in the shared project package/header.
REQ-029 The synchronizer SHALL be a separate sub-module sync_2ff, reused for other asynchronous status inputs.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, RELEASE_GAP=4)
REQ-030 Release reset_n at edge 0, locked rises after edge 6 -> pll_rst high edges 0-3; core_reset_n rises at edge 18, panel_reset_n and ready at edge 22.
REQ-031 locked held low -> pll_rst re-pulses every 24 cycles; timeout_count increments per retry, saturates at 255 after 255 retries.
REQ-032 locked glitches low for 1 cycle in STABLE -> no release; stable count restarts from 8 on re-lock.
REQ-033 locked drops in RUN -> all three outputs low 3 edges later, lock_lost_count=1; re-lock repeats full release sequence.
REQ-034 reset_n asserted in RELEASE -> outputs at reset values without waiting for an edge; counts cleared.
REQ-035 Assertion throughout all tests: panel_reset_n never 1 while core_reset_n is 0.
